squeeze_piso: RTL and testbench

SQUEEZE_PISO -- requirements
Module: squeeze_piso

---
 rtl/keccak_pkg.sv | 13 +
 rtl/piso_shift_reg.sv | 27 ++
 rtl/squeeze_piso.sv | 90 +++++++++
 tb/tb_squeeze_piso.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// Shared Keccak geometry and squeeze FSM encoding, used by both the absorb and squeeze paths.
package keccak_pkg;
  localparam int DATA_SIZE  = 64;
  localparam int RATE_BITS  = 1344;
  localparam int RATE_WORDS = RATE_BITS / DATA_SIZE;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_BLK = 2'd1,
    ST_SHIFT    = 2'd2,
    ST_DONE     = 2'd3
  } sq_state_e;
endpackage

// File: rtl/piso_shift_reg.sv
// Rate-wide parallel-load register that shifts left by one word per step, zero-filling the LSBs.
module piso_shift_reg #(
  parameter int W    = 1344,
  parameter int STEP = 64
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);
  logic [W-1:0] sr_d, sr_q;

  always_comb begin
    sr_d = sr_q;
    if (load)       sr_d = din;
    else if (shift) sr_d = sr_q << STEP;
  end

  always_ff @(posedge clk) begin
    if (clr) sr_q <= '0;
    else     sr_q <= sr_d;
  end

  assign q = sr_q;
endmodule

// File: rtl/squeeze_piso.sv
// Squeeze-side output serializer: emits out_len words MSB-first, requesting new blocks as each is drained.
module squeeze_piso
  import keccak_pkg::*;
#(
  parameter int DATA_SIZE = keccak_pkg::DATA_SIZE,
  parameter int RATE_BITS = keccak_pkg::RATE_BITS
) (
  input  logic                 clk,
  input  logic                 hash_init,
  input  logic                 start,
  input  logic [15:0]          out_len,
  input  logic                 load,
  input  logic [RATE_BITS-1:0] data_in,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 out_valid,
  output logic                 need_block,
  output logic                 squeeze_done,
  output logic [4:0]           word_idx
);
  localparam int         N_WORDS  = RATE_BITS / DATA_SIZE;
  localparam logic [4:0] LAST_IDX = 5'(N_WORDS - 1);

  sq_state_e            state_d, state_q;
  logic [15:0]          rem_d, rem_q;
  logic [4:0]           idx_d, idx_q;
  logic                 sr_load, sr_shift;
  logic [RATE_BITS-1:0] sr_q;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          rem_d   = out_len;
          state_d = (out_len != 16'd0) ? ST_WAIT_BLK : ST_DONE;
        end
      end
      ST_WAIT_BLK: begin
        if (load) begin
          sr_load = 1'b1;
          idx_d   = 5'd0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // rem_q is nonzero whenever SHIFT is entered, so the decrement cannot wrap
        if (out_ready) begin
          sr_shift = 1'b1;
          rem_d    = rem_q - 16'd1;
          idx_d    = (idx_q == LAST_IDX) ? 5'd0 : idx_q + 5'd1;
          if (rem_q == 16'd1)         state_d = ST_DONE;
          else if (idx_q == LAST_IDX) state_d = ST_WAIT_BLK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (hash_init) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
    end
  end

  piso_shift_reg #(.W(RATE_BITS), .STEP(DATA_SIZE)) u_sr (
    .clk  (clk),
    .clr  (hash_init),
    .load (sr_load),
    .shift(sr_shift),
    .din  (data_in),
    .q    (sr_q)
  );

  assign data_out     = sr_q[RATE_BITS-1 -: DATA_SIZE];
  assign out_valid    = (state_q == ST_SHIFT);
  assign need_block   = (state_q == ST_WAIT_BLK);
  assign squeeze_done = (state_q == ST_DONE);
  assign word_idx     = idx_q;
endmodule

// File: tb/tb_squeeze_piso.sv
// Self-checking bench for squeeze_piso: directed scenarios with literal expectations plus a random soak
// against a word-queue model of the squeeze.
module tb_squeeze_piso;
  localparam int DW = 64;
  localparam int RB = 1344;
  localparam int NW = RB / DW;

  logic          clk = 1'b0;
  logic          hash_init = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   out_len = '0;
  logic          load = 1'b0;
  logic [RB-1:0] data_in = '0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] data_out;
  logic          out_valid, need_block, squeeze_done;
  logic [4:0]    word_idx;

  int checks = 0;
  int errors = 0;

  squeeze_piso dut (
    .clk(clk), .hash_init(hash_init), .start(start), .out_len(out_len),
    .load(load), .data_in(data_in), .out_ready(out_ready), .data_out(data_out),
    .out_valid(out_valid), .need_block(need_block), .squeeze_done(squeeze_done),
    .word_idx(word_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a squeeze is "active" once started; words left to emit, and a copy of the loaded
  // block with a read pointer. Register contents past the pointer read as zero.
  logic [DW-1:0] m_blk [NW];
  int            m_pos = 0;
  int            m_rem = 0;
  bit            m_active = 0;
  bit            m_have = 0;

  task automatic model_step();
    if (hash_init) begin
      for (int w = 0; w < NW; w++) m_blk[w] = '0;
      m_pos = 0; m_rem = 0; m_active = 0; m_have = 0;
    end else if (!m_active || m_rem == 0) begin
      if (start) begin
        m_active = 1; m_rem = int'(out_len); m_have = 0;
      end
    end else if (!m_have) begin
      if (load) begin
        for (int w = 0; w < NW; w++) m_blk[w] = data_in[RB-1-DW*w -: DW];
        m_pos = 0; m_have = 1;
      end
    end else if (out_ready) begin
      m_pos++; m_rem--;
      if (m_pos == NW) m_have = 0;
    end
  endtask

  initial begin
    for (int w = 0; w < NW; w++) m_blk[w] = '0;
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("m_valid", 64'(out_valid),    64'(m_active && m_rem > 0 && m_have));
      chk("m_need",  64'(need_block),   64'(m_active && m_rem > 0 && !m_have));
      chk("m_done",  64'(squeeze_done), 64'(m_active && m_rem == 0));
      chk("m_data",  data_out, (m_pos < NW) ? m_blk[m_pos] : 64'd0);
      if (out_valid) chk("m_idx", 64'(word_idx), 64'(m_pos));
    end
  end

  task automatic step(); @(negedge clk); endtask

  function automatic logic [RB-1:0] ramp_block();
    logic [RB-1:0] b;
    logic [63:0]   k;
    b = '0;
    for (int w = 0; w < NW; w++) begin
      k = 64'(w);
      b[RB-1-DW*w -: DW] = k * 64'h1111_1111_1111_1111;
    end
    return b;
  endfunction

  function automatic logic [RB-1:0] rand_block();
    logic [RB-1:0] b;
    for (int i = 0; i < RB/32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic begin_squeeze(input logic [15:0] len);
    start = 1'b1; out_len = len; step(); start = 1'b0;
  endtask

  task automatic do_reset();
    hash_init = 1'b1; step(); hash_init = 1'b0;
  endtask

  initial begin
    logic [RB-1:0] a5blk;
    out_ready = 1'b1;
    step(); step();
    chk("rst_data", data_out, 64'd0);
    chk("rst_flags", {61'd0, out_valid, need_block, squeeze_done}, 64'd0);
    chk("rst_idx", 64'(word_idx), 64'd0);
    hash_init = 1'b0;

    // Four words out of the ramp block, then done without asking for another block
    begin_squeeze(16'd4);
    chk("s1_need", 64'(need_block), 64'd1);
    load = 1'b1; data_in = ramp_block(); step(); load = 1'b0;
    chk("s1_w0", data_out, 64'h0); step();
    chk("s1_w1", data_out, 64'h1111_1111_1111_1111); step();
    chk("s1_w2", data_out, 64'h2222_2222_2222_2222); step();
    chk("s1_w3", data_out, 64'h3333_3333_3333_3333); step();
    chk("s1_done", 64'(squeeze_done), 64'd1);
    chk("s1_need0", 64'(need_block), 64'd0);
    step();
    chk("s1_hold", 64'(squeeze_done), 64'd1);

    // 25 words spanning two blocks
    begin_squeeze(16'd25);
    load = 1'b1; data_in = ramp_block(); step(); load = 1'b0;
    for (int i = 0; i < NW; i++) step();
    chk("s2_need", 64'(need_block), 64'd1);
    chk("s2_valid0", 64'(out_valid), 64'd0);
    for (int i = 0; i < RB/8; i++) a5blk[i*8 +: 8] = 8'hA5;
    load = 1'b1; data_in = a5blk; step(); load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("s2_a5", data_out, 64'hA5A5_A5A5_A5A5_A5A5);
      step();
    end
    chk("s2_done", 64'(squeeze_done), 64'd1);

    // Back-pressure after word 2 for three cycles
    begin_squeeze(16'd6);
    load = 1'b1; data_in = ramp_block(); step(); load = 1'b0;
    step(); step();
    chk("s3_w2", data_out, 64'h2222_2222_2222_2222);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s3_hold", data_out, 64'h2222_2222_2222_2222);
      chk("s3_idx", 64'(word_idx), 64'd2);
    end
    out_ready = 1'b1; step();
    chk("s3_w3", data_out, 64'h3333_3333_3333_3333);
    step(); step(); step();
    chk("s3_done", 64'(squeeze_done), 64'd1);

    // Reset in the middle of a block; loads afterwards go nowhere
    begin_squeeze(16'd30);
    load = 1'b1; data_in = ramp_block(); step(); load = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("s4_idx5", 64'(word_idx), 64'd5);
    hash_init = 1'b1; start = 1'b1; load = 1'b1; step();
    hash_init = 1'b0; start = 1'b0;
    chk("s4_data", data_out, 64'd0);
    chk("s4_flags", {59'd0, word_idx == 5'd0 ? 1'b0 : 1'b1, out_valid, need_block, squeeze_done}, 64'd0);
    data_in = rand_block();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s4_ign_v", 64'(out_valid), 64'd0);
      chk("s4_ign_d", data_out, 64'd0);
    end
    load = 1'b0;

    // Zero-length squeeze
    begin_squeeze(16'd0);
    chk("s5_done", 64'(squeeze_done), 64'd1);
    chk("s5_nv", 64'(need_block | out_valid), 64'd0);
    step();
    chk("s5_nv2", 64'(need_block | out_valid), 64'd0);

    // Random soak: stray loads and starts, back-pressure, occasional reset
    do_reset();
    for (int c = 0; c < 6000; c++) begin
      int r;
      r = int'($urandom_range(0, 999));
      hash_init = (r < 2);
      start = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 5))
        0:       out_len = 16'd0;
        1:       out_len = 16'(NW);
        2:       out_len = 16'(NW + 1);
        3:       out_len = 16'(2 * NW);
        default: out_len = 16'($urandom_range(1, 60));
      endcase
      load = ($urandom_range(0, 2) == 0);
      if (load) data_in = rand_block();
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    hash_init = 1'b0; start = 1'b0; load = 1'b0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
